text_display_char_scanner: RTL

Upstream sequencer for the text display path. On a start request it walks every cell of the character buffer in raster order, fetches each character code, publishes the cell's pixel origin, and drives `display_char` to the downstream 8x16 glyph offset counter. It holds `display_char` until that counter reports `done_char`, then advances to the next cell. It reports completion with a one-cycle `frame_done` pulse.

---
 rtl/text_display_pkg.sv | 10 +
 rtl/text_display_cursor.sv | 43 ++++
 rtl/text_display_char_scanner.sv | 70 +++++++
 3 files changed

// File: rtl/text_display_pkg.sv
// text_display_pkg: shared constants and state encoding for the text display path
package text_display_pkg;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int COLS_DEF = 40;
  localparam int ROWS_DEF = 15;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, DRAW, ADVANCE} state_t;
endpackage

// File: rtl/text_display_cursor.sv
// text_display_cursor: raster cursor holding col/row, buffer address and pixel origin
// ports: clk, rst (sync, active-high); clear zeroes the cursor; step advances one cell;
// addr/base_x/base_y are the registered cell address and pixel origin; last_cell flags the final cell
module text_display_cursor
  import text_display_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    base_x,
  output logic [Y_W-1:0]    base_y,
  output logic              last_cell
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic last_col;
  assign last_col = col == CW'(COLS - 1);
  assign last_cell = last_col && row == RW'(ROWS - 1);
  // origin and address advance incrementally so no multiplier is needed
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
      addr <= '0;
      base_x <= '0;
      base_y <= '0;
    end else if (step) begin
      addr <= addr + 1'b1;
      col <= last_col ? '0 : col + 1'b1;
      base_x <= last_col ? '0 : base_x + X_W'(CHAR_W);
      row <= last_col ? row + 1'b1 : row;
      base_y <= last_col ? base_y + Y_W'(CHAR_H) : base_y;
    end
  end
endmodule

// File: rtl/text_display_char_scanner.sv
// text_display_char_scanner: walks the character buffer and sequences one glyph draw per cell
// ports: clk, rst (sync, active-high); start requests a frame (IDLE only); done_char ends a glyph;
// char_data is sync RAM read data; char_addr/char_code/base_x/base_y describe the current cell;
// display_char enables the glyph counter; busy is high outside IDLE; frame_done pulses after the last cell
module text_display_char_scanner
  import text_display_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done_char,
  input  logic [7:0]        char_data,
  output logic [ADDR_W-1:0] char_addr,
  output logic [7:0]        char_code,
  output logic [X_W-1:0]    base_x,
  output logic [Y_W-1:0]    base_y,
  output logic              display_char,
  output logic              busy,
  output logic              frame_done
);
  state_t state, state_n;
  logic clear, step, last_cell;
  always_comb begin
    state_n = state;
    clear = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        state_n = start ? ADDR : IDLE;
        clear = start;
      end
      ADDR: state_n = LATCH;
      LATCH: state_n = DRAW;
      DRAW: state_n = done_char ? ADVANCE : DRAW;
      ADVANCE: begin
        state_n = last_cell ? IDLE : ADDR;
        step = !last_cell;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      char_code <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      frame_done <= state == ADVANCE && last_cell;
      if (state == LATCH) char_code <= char_data;
    end
  end
  assign display_char = state == DRAW;
  text_display_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .step(step),
    .addr(char_addr),
    .base_x(base_x),
    .base_y(base_y),
    .last_cell(last_cell)
  );
endmodule
